// File: rtl/fib_seq_checker.sv
`default_nettype none
// fib_seq_checker: checks a valid/ready stream against the Fibonacci sequence 1,1,2,3,5,...
// Define FIB_CHK_TIMEOUT_EN to add an idle watchdog that fails CHECK after TIMEOUT empty cycles.
module fib_seq_checker #(
  parameter int  WIDTH     = 32,
  parameter int  NUM_TERMS = 8,
  parameter int  TIMEOUT   = 64,
  localparam int CW        = $clog2(NUM_TERMS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             pass,
  output logic             fail,
  output logic             overflow,
  output logic             timeout,
  output logic [CW-1:0]    term_cnt,
  output logic [WIDTH-1:0] expected,
  output logic [WIDTH-1:0] err_data
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_PASS  = 2'd2,
    S_FAIL  = 2'd3
  } state_t;

  localparam logic [CW-1:0]    LAST_CNT = CW'(NUM_TERMS);
  localparam logic [WIDTH-1:0] SEED_CUR = WIDTH'(1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   exp_prev_q, exp_prev_d;
  logic [WIDTH-1:0]   exp_cur_q, exp_cur_d;
  logic [CW-1:0]      term_cnt_q, term_cnt_d;
  logic [WIDTH-1:0]   err_data_q, err_data_d;
  logic               overflow_q, overflow_d;
  logic               accept;
  logic               match;
  logic [WIDTH:0]     sum;

`ifdef FIB_CHK_TIMEOUT_EN
  localparam int           TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] IDLE_LIM = TW'(TIMEOUT);
  logic [TW-1:0] idle_q, idle_d;
  logic          timeout_q, timeout_d;
`else
  logic [31:0]   unused_timeout_param;
  assign unused_timeout_param = TIMEOUT;
`endif

  // start wins over any beat presented in the same cycle
  assign in_ready = (state_q == S_CHECK) && !start;
  assign accept   = in_valid && in_ready;
  assign match    = (in_data == exp_cur_q);
  assign sum      = {1'b0, exp_cur_q} + {1'b0, exp_prev_q};

  always_comb begin
    state_d    = state_q;
    exp_prev_d = exp_prev_q;
    exp_cur_d  = exp_cur_q;
    term_cnt_d = term_cnt_q;
    err_data_d = err_data_q;
    overflow_d = overflow_q;
`ifdef FIB_CHK_TIMEOUT_EN
    idle_d     = idle_q;
    timeout_d  = timeout_q;
`endif
    if (start) begin
      state_d    = S_CHECK;
      exp_prev_d = '0;
      exp_cur_d  = SEED_CUR;
      term_cnt_d = '0;
      err_data_d = '0;
      overflow_d = 1'b0;
`ifdef FIB_CHK_TIMEOUT_EN
      idle_d     = '0;
      timeout_d  = 1'b0;
`endif
    end else if (state_q == S_CHECK) begin
      if (accept) begin
        if (match) begin
          exp_prev_d = exp_cur_q;
          exp_cur_d  = sum[WIDTH-1:0];
          term_cnt_d = term_cnt_q + CW'(1);
          // completing the run outranks a carry on the final term
          if (term_cnt_q + CW'(1) == LAST_CNT) begin
            state_d = S_PASS;
          end else if (sum[WIDTH]) begin
            overflow_d = 1'b1;
            state_d    = S_FAIL;
          end
        end else begin
          err_data_d = in_data;
          state_d    = S_FAIL;
        end
      end
`ifdef FIB_CHK_TIMEOUT_EN
      if (accept) begin
        idle_d = '0;
      end else begin
        idle_d = idle_q + TW'(1);
        if (idle_q + TW'(1) == IDLE_LIM) begin
          timeout_d = 1'b1;
          state_d   = S_FAIL;
        end
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      exp_prev_q <= '0;
      exp_cur_q  <= SEED_CUR;
      term_cnt_q <= '0;
      err_data_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      exp_prev_q <= exp_prev_d;
      exp_cur_q  <= exp_cur_d;
      term_cnt_q <= term_cnt_d;
      err_data_q <= err_data_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef FIB_CHK_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      idle_q    <= idle_d;
      timeout_q <= timeout_d;
    end
  end
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign pass     = (state_q == S_PASS);
  assign fail     = (state_q == S_FAIL);
  assign overflow = overflow_q;
  assign term_cnt = term_cnt_q;
  assign expected = exp_cur_q;
  assign err_data = err_data_q;

endmodule
`default_nettype wire

// File: tb/tb_fib_seq_checker.sv
`default_nettype none
// tb_fib_seq_checker: randomized self-checking bench against an arithmetic Fibonacci model.
module tb_fib_seq_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, in_valid;
  logic [31:0] in_data;
  logic        in_ready, pass, fail, overflow, timeout;
  logic [3:0]  term_cnt;
  logic [31:0] expected, err_data;

  logic        start8, valid8;
  logic [7:0]  data8;
  logic        ready8, pass8, fail8, ovf8, tmo8;
  logic [4:0]  cnt8;
  logic [7:0]  exp8, err8;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fib_seq_checker #(.WIDTH(32), .NUM_TERMS(8), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .pass(pass), .fail(fail), .overflow(overflow), .timeout(timeout),
    .term_cnt(term_cnt), .expected(expected), .err_data(err_data)
  );

  fib_seq_checker #(.WIDTH(8), .NUM_TERMS(20), .TIMEOUT(16)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .in_valid(valid8), .in_data(data8),
    .in_ready(ready8), .pass(pass8), .fail(fail8), .overflow(ovf8), .timeout(tmo8),
    .term_cnt(cnt8), .expected(exp8), .err_data(err8)
  );

  // n-th Fibonacci term, 1-indexed: fib(1)=1, fib(2)=1, fib(3)=2, ...
  function automatic longint unsigned fib(input int n);
    longint unsigned a = 0, b = 1, t;
    for (int i = 1; i < n; i++) begin
      t = a + b; a = b; b = t;
    end
    return b;
  endfunction

  task automatic beat(input logic [31:0] d);
    @(negedge clk); in_valid = 1'b1; in_data = d;
  endtask

  task automatic idle_cyc();
    @(negedge clk); in_valid = 1'b0; in_data = $urandom;
  endtask

  task automatic do_start();
    @(negedge clk); start = 1'b1; in_valid = 1'b0;
    @(negedge clk); start = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got=%0d want=0", in_ready); end
    n_cmp++; if ({pass, fail, overflow, timeout} !== 4'b0) begin n_fail++; $display("FAIL rst_flags got=%b want=0000", {pass, fail, overflow, timeout}); end
    n_cmp++; if (term_cnt !== 4'd0) begin n_fail++; $display("FAIL rst_cnt got=%0d want=0", term_cnt); end
    n_cmp++; if (expected !== 32'd1) begin n_fail++; $display("FAIL rst_expected got=%0d want=1", expected); end
    n_cmp++; if (err_data !== 32'd0) begin n_fail++; $display("FAIL rst_err got=%0d want=0", err_data); end
    n_cmp++; if (exp8 !== 8'd1 || cnt8 !== 5'd0) begin n_fail++; $display("FAIL rst_dut8 got exp=%0d cnt=%0d want exp=1 cnt=0", exp8, cnt8); end
  endtask

  task automatic test_pass_stream();
    do_start();
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL s1_ready_after_start got=%0d want=1", in_ready); end
    for (int i = 1; i <= 8; i++) beat(32'(fib(i)));
    idle_cyc();
    n_cmp++; if (pass !== 1'b1 || fail !== 1'b0) begin n_fail++; $display("FAIL s1_pass got pass=%0d fail=%0d want 1/0", pass, fail); end
    n_cmp++; if (term_cnt !== 4'd8) begin n_fail++; $display("FAIL s1_cnt got=%0d want=8", term_cnt); end
    n_cmp++; if (expected !== 32'(fib(9))) begin n_fail++; $display("FAIL s1_expected got=%0d want=%0d", expected, fib(9)); end
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL s1_ready_in_pass got=%0d want=0", in_ready); end
  endtask

  task automatic test_mismatch();
    do_start();
    beat(32'd1); beat(32'd1); beat(32'd2); beat(32'd4);
    idle_cyc();
    n_cmp++; if (fail !== 1'b1 || pass !== 1'b0) begin n_fail++; $display("FAIL s2_fail got fail=%0d pass=%0d want 1/0", fail, pass); end
    n_cmp++; if (err_data !== 32'd4) begin n_fail++; $display("FAIL s2_err got=%0d want=4", err_data); end
    n_cmp++; if (expected !== 32'(fib(4))) begin n_fail++; $display("FAIL s2_expected got=%0d want=%0d", expected, fib(4)); end
    n_cmp++; if (term_cnt !== 4'd3) begin n_fail++; $display("FAIL s2_cnt got=%0d want=3", term_cnt); end
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL s2_ready got=%0d want=0", in_ready); end
    beat(32'd3); idle_cyc();
    n_cmp++; if (fail !== 1'b1 || term_cnt !== 4'd3) begin n_fail++; $display("FAIL s2_terminal got fail=%0d cnt=%0d want 1/3", fail, term_cnt); end
    do_start();
    n_cmp++; if (fail !== 1'b0 || err_data !== 32'd0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL s2_restart got fail=%0d err=%0d ready=%0d want 0/0/1", fail, err_data, in_ready); end
  endtask

  task automatic test_random_mismatch();
    int k;
    logic [31:0] bad;
    repeat (5) begin
      k = $urandom_range(1, 8);
      bad = 32'(fib(k)) + 32'($urandom_range(1, 1000));
      do_start();
      for (int i = 1; i < k; i++) beat(32'(fib(i)));
      beat(bad);
      idle_cyc();
      n_cmp++; if (fail !== 1'b1 || err_data !== bad) begin n_fail++; $display("FAIL rnd_mm k=%0d got fail=%0d err=%0d want 1/%0d", k, fail, err_data, bad); end
      n_cmp++; if (expected !== 32'(fib(k)) || term_cnt !== 4'(k - 1)) begin n_fail++; $display("FAIL rnd_mm_state k=%0d got exp=%0d cnt=%0d want %0d/%0d", k, expected, term_cnt, fib(k), k - 1); end
    end
  endtask

  task automatic test_overflow();
    @(negedge clk); start8 = 1'b1; valid8 = 1'b0;
    @(negedge clk); start8 = 1'b0;
    for (int i = 1; i <= 13; i++) begin
      @(negedge clk); valid8 = 1'b1; data8 = 8'(fib(i));
    end
    @(negedge clk); valid8 = 1'b0;
    n_cmp++; if (ovf8 !== 1'b1 || fail8 !== 1'b1 || pass8 !== 1'b0) begin n_fail++; $display("FAIL s3_ovf got ovf=%0d fail=%0d pass=%0d want 1/1/0", ovf8, fail8, pass8); end
    n_cmp++; if (cnt8 !== 5'd13) begin n_fail++; $display("FAIL s3_cnt got=%0d want=13", cnt8); end
    n_cmp++; if (exp8 !== 8'(fib(14))) begin n_fail++; $display("FAIL s3_trunc got=%0d want=%0d", exp8, 8'(fib(14))); end
  endtask

  task automatic test_restart();
    do_start();
    beat(32'd1); beat(32'd1); beat(32'd2);
    @(negedge clk); start = 1'b1; in_valid = 1'b1; in_data = 32'd3;
    @(negedge clk); start = 1'b0; in_valid = 1'b0;
    #1;
    n_cmp++; if (term_cnt !== 4'd0 || expected !== 32'd1) begin n_fail++; $display("FAIL s4_restart got cnt=%0d exp=%0d want 0/1", term_cnt, expected); end
    for (int i = 1; i <= 8; i++) beat(32'(fib(i)));
    idle_cyc();
    n_cmp++; if (pass !== 1'b1 || term_cnt !== 4'd8) begin n_fail++; $display("FAIL s4_pass got pass=%0d cnt=%0d want 1/8", pass, term_cnt); end
  endtask

  task automatic test_async_reset();
    do_start();
    beat(32'd1); beat(32'd1); beat(32'd2);
    @(posedge clk); #2 rst_n = 1'b0; in_valid = 1'b0;
    #1;
    n_cmp++; if (term_cnt !== 4'd0 || expected !== 32'd1 || err_data !== 32'd0) begin n_fail++; $display("FAIL s4_async got cnt=%0d exp=%0d err=%0d want 0/1/0", term_cnt, expected, err_data); end
    n_cmp++; if ({in_ready, pass, fail, overflow, timeout} !== 5'b0) begin n_fail++; $display("FAIL s4_async_flags got=%b want=00000", {in_ready, pass, fail, overflow, timeout}); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_gaps();
    do_start();
    for (int i = 1; i <= 8; i++) begin
      beat(32'(fib(i)));
      if (i <= 3) repeat (5) idle_cyc();
      else if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) idle_cyc();
    end
    idle_cyc();
    n_cmp++; if (pass !== 1'b1 || fail !== 1'b0) begin n_fail++; $display("FAIL s5_pass got pass=%0d fail=%0d want 1/0", pass, fail); end
    n_cmp++; if (term_cnt !== 4'd8 || expected !== 32'(fib(9))) begin n_fail++; $display("FAIL s5_state got cnt=%0d exp=%0d want 8/%0d", term_cnt, expected, fib(9)); end
  endtask

  task automatic test_timeout();
    do_start();
    beat(32'd1); beat(32'd1);
    idle_cyc();
`ifdef FIB_CHK_TIMEOUT_EN
    repeat (15) @(negedge clk);
    n_cmp++; if (fail !== 1'b0) begin n_fail++; $display("FAIL s6_early got fail=%0d want=0", fail); end
    @(negedge clk);
    n_cmp++; if (fail !== 1'b1 || timeout !== 1'b1) begin n_fail++; $display("FAIL s6_timeout got fail=%0d tmo=%0d want 1/1", fail, timeout); end
    n_cmp++; if (term_cnt !== 4'd2) begin n_fail++; $display("FAIL s6_cnt got=%0d want=2", term_cnt); end
`else
    repeat (40) @(negedge clk);
    n_cmp++; if (fail !== 1'b0 || timeout !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL s6_no_wd got fail=%0d tmo=%0d ready=%0d want 0/0/1", fail, timeout, in_ready); end
    n_cmp++; if (term_cnt !== 4'd2 || expected !== 32'(fib(3))) begin n_fail++; $display("FAIL s6_hold got cnt=%0d exp=%0d want 2/%0d", term_cnt, expected, fib(3)); end
`endif
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
    start8 = 1'b0; valid8 = 1'b0; data8 = '0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_pass_stream();
    test_mismatch();
    test_random_mismatch();
    test_overflow();
    test_restart();
    test_async_reset();
    test_gaps();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
